hash_sweep_ctrl: RTL and testbench

Sequencer for the 8-character, 7-bit-per-character initial-hash pipeline. It enumerates every 56-bit candidate string over a configurable character range, drives one candidate per cycle into the free-running hash pipeline, and tracks in-flight validity. It compares each returned hash with a target and queues matching strings in a match FIFO with a valid/ready drain port. It sits between the host/config logic and the hash datapath.

---
 rtl/hash_sweep_pkg.sv | 45 ++++
 rtl/hash_match_fifo.sv | 55 +++++
 rtl/hash_sweep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hash_sweep_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_sweep_pkg.sv
// Shared types and helpers for the initial-hash sweep sequencer.
// A candidate string is 8 characters of 7 bits, character k in bits [7k+6:7k].
package hash_sweep_pkg;

    localparam int CHAR_W    = 7;
    localparam int NUM_CHARS = 8;
    localparam int STR_W     = CHAR_W * NUM_CHARS;
    localparam int HASH_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [STR_W-1:0]  str_t;

    // String with every character position set to c
    function automatic str_t fill_str(input char_t c);
        return {NUM_CHARS{c}};
    endfunction

    // Odometer step: digit 0 is least significant; a digit sitting at hi
    // wraps to lo and carries into the next digit.
    function automatic str_t odo_next(input str_t cur, input char_t lo, input char_t hi);
        str_t nxt;
        logic carry;
        nxt   = cur;
        carry = 1'b1;
        for (int k = 0; k < NUM_CHARS; k++) begin
            if (carry) begin
                if (cur[k*CHAR_W +: CHAR_W] == hi) begin
                    nxt[k*CHAR_W +: CHAR_W] = lo;
                end else begin
                    nxt[k*CHAR_W +: CHAR_W] = cur[k*CHAR_W +: CHAR_W] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hash_match_fifo.sv
// Synchronous FIFO holding matching strings. Reports its occupancy so the
// sequencer can reserve room for every candidate still in the hash pipeline.
// A push and a pop in the same cycle leave the count unchanged.
module hash_match_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 56
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop_ready,
    output logic                       rd_valid,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign rd_valid = (count != '0);
    assign do_pop   = pop_ready && rd_valid;
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    // Head is forced to zero while empty so the port never shows stale data
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are qualified by count, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hash_sweep_ctrl.sv
// Sweep sequencer for the 8-character initial-hash pipeline.
// Enumerates every candidate over [char_lo, char_hi]^8, issues one per cycle
// when there is guaranteed room for its result, compares returned hashes
// with the target and queues matching strings for a valid/ready consumer.
// Optional build macro HASH_SWEEP_PERF_EN adds perf_issued / perf_stall.
module hash_sweep_ctrl
    import hash_sweep_pkg::*;
#(
    parameter int HASH_LATENCY = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed,
    input  logic [31:0]       target,
    input  logic [6:0]        char_lo,
    input  logic [6:0]        char_hi,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [STR_W-1:0]  hp_chars,
    output logic [31:0]       hp_seed,
    input  logic [HASH_W-1:0] hp_hash,
`ifdef HASH_SWEEP_PERF_EN
    output logic [63:0]       perf_issued,
    output logic [31:0]       perf_stall,
`endif
    output logic              match_valid,
    input  logic              match_ready,
    output logic [STR_W-1:0]  match_str
);

    localparam int INF_W  = $clog2(HASH_LATENCY+1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
    localparam int OCC_W  = FCNT_W + 1;

    sweep_state_t      state;
    char_t             lo_r;
    char_t             hi_r;
    logic [31:0]       target_r;
    logic [HASH_LATENCY-1:0] vld_line;
    str_t              str_line [HASH_LATENCY];
    logic [INF_W-1:0]  inflight;
    logic [FCNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]  occupancy;
    logic              credit_ok;
    logic              issue;
    logic              match_push;

    // Candidates currently travelling through the hash pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < HASH_LATENCY; i++) begin
            inflight = inflight + INF_W'(vld_line[i]);
        end
    end

    // Every issued candidate may match, so the FIFO must have a slot reserved
    // for each one in flight; this is what makes a dropped match impossible.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign credit_ok  = (occupancy < OCC_W'(FIFO_DEPTH));
    assign issue      = (state == RUN) && !abort && credit_ok;
    assign match_push = vld_line[HASH_LATENCY-1] && (hp_hash == target_r);

    // Sweep FSM with registered status outputs; hp_chars is the odometer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            hp_chars  <= '0;
            hp_seed   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hp_seed   <= seed;
                        range_err <= (char_lo > char_hi);
                        if (char_lo > char_hi) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            hp_chars <= fill_str(char_lo);
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= DRAIN;
                    end else if (issue) begin
                        // The all-hi string is the final candidate; hold it
                        if (hp_chars == fill_str(hi_r)) begin
                            state <= DRAIN;
                        end else begin
                            hp_chars <= odo_next(hp_chars, lo_r, hi_r);
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sweep configuration captured on an accepted start, held until DONE
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            lo_r     <= char_lo;
            hi_r     <= char_hi;
            target_r <= target;
        end
    end

    // Valid delay line aligned with the hash pipeline latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_line <= '0;
        end else begin
            vld_line <= {vld_line[HASH_LATENCY-2:0], issue};
        end
    end

    // Candidate delay line; entries are qualified by vld_line
    always_ff @(posedge clk) begin
        str_line[0] <= hp_chars;
        for (int i = 1; i < HASH_LATENCY; i++) begin
            str_line[i] <= str_line[i-1];
        end
    end

    hash_match_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (STR_W)
    ) u_match_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (match_push),
        .push_data (str_line[HASH_LATENCY-1]),
        .pop_ready (match_ready),
        .rd_valid  (match_valid),
        .rd_data   (match_str),
        .count     (fifo_count)
    );

`ifdef HASH_SWEEP_PERF_EN
    logic stall;
    assign stall = (state == RUN) && !abort && !credit_ok;

    // Issue and throttle counters, cleared on each accepted start, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (state == IDLE && start) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue && (perf_issued != '1)) perf_issued <= perf_issued + 64'd1;
            if (stall && (perf_stall != '1))  perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hash_sweep_ctrl.sv
// Directed bench for hash_sweep_ctrl with a behavioural 8-stage hash pipeline.
module tb_hash_sweep_ctrl;

    localparam int HASH_LATENCY = 8;
    localparam int FIFO_DEPTH   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] seed = 32'd0;
    logic [31:0] target = 32'd0;
    logic [6:0]  char_lo = 7'd0;
    logic [6:0]  char_hi = 7'd0;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [55:0] hp_chars;
    logic [31:0] hp_seed;
    logic [31:0] hp_hash;
    logic        match_valid;
    logic        match_ready = 1'b0;
    logic [55:0] match_str;

    logic        force_match = 1'b0;
    logic [31:0] pipe [HASH_LATENCY];
    logic [55:0] pop_q [$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hash_sweep_ctrl #(
        .HASH_LATENCY (HASH_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .seed        (seed),
        .target      (target),
        .char_lo     (char_lo),
        .char_hi     (char_hi),
        .busy        (busy),
        .done        (done),
        .range_err   (range_err),
        .hp_chars    (hp_chars),
        .hp_seed     (hp_seed),
        .hp_hash     (hp_hash),
        .match_valid (match_valid),
        .match_ready (match_ready),
        .match_str   (match_str)
    );

    // djb2-style reference hash, char0 first
    function automatic logic [31:0] model_hash(input logic [55:0] s, input logic [31:0] sd);
        logic [31:0] h;
        h = sd;
        for (int k = 0; k < 8; k++) h = (h << 5) + h + {25'd0, s[k*7 +: 7]};
        return h;
    endfunction

    // n-th candidate of a sweep with radix r starting at lo (digit 0 least significant)
    function automatic logic [55:0] cand(input int n, input logic [6:0] lo, input int r);
        logic [55:0] s;
        int q;
        q = n;
        for (int k = 0; k < 8; k++) begin
            s[k*7 +: 7] = lo + 7'(q % r);
            q = q / r;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= model_hash(hp_chars, hp_seed);
        for (int i = 1; i < HASH_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign hp_hash = force_match ? target : pipe[HASH_LATENCY-1];

    always @(negedge clk) begin
        if (rst_n && match_valid && match_ready) pop_q.push_back(match_str);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_sweep(input logic [6:0] lo, input logic [6:0] hi,
                               input logic [31:0] sd, input logic [31:0] tg);
        @(posedge clk); #1;
        char_lo = lo; char_hi = hi; seed = sd; target = tg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
        vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL reset_range_err: got %0b want 0", range_err); end
        vectors++; if (hp_chars !== 56'd0) begin miscompares++; $display("FAIL reset_hp_chars: got %h want 0", hp_chars); end
        vectors++; if (hp_seed !== 32'd0) begin miscompares++; $display("FAIL reset_hp_seed: got %h want 0", hp_seed); end
        vectors++; if (match_valid !== 1'b0) begin miscompares++; $display("FAIL reset_match_valid: got %0b want 0", match_valid); end
        vectors++; if (match_str !== 56'd0) begin miscompares++; $display("FAIL reset_match_str: got %h want 0", match_str); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [55:0] aa;
        logic [31:0] tg;
        int cyc;
        aa = {8{7'h41}};
        tg = model_hash(aa, 32'h1505);
        match_ready = 1'b0;
        start_sweep(7'h41, 7'h41, 32'h1505, tg);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %0b want 1", busy); end
        vectors++; if (hp_chars !== aa) begin miscompares++; $display("FAIL single_first_chars: got %h want %h", hp_chars, aa); end
        vectors++; if (hp_seed !== 32'h1505) begin miscompares++; $display("FAIL single_hp_seed: got %h want 1505", hp_seed); end
        wait_done(40, cyc);
        vectors++; if (cyc != 10) begin miscompares++; $display("FAIL single_done_latency: got %0d want 10", cyc); end
        vectors++; if (match_valid !== 1'b1) begin miscompares++; $display("FAIL single_match_valid: got %0b want 1", match_valid); end
        vectors++; if (match_str !== aa) begin miscompares++; $display("FAIL single_match_str: got %h want %h", match_str, aa); end
        match_ready = 1'b1;
        @(posedge clk); #1;
        match_ready = 1'b0;
        vectors++; if (match_valid !== 1'b0) begin miscompares++; $display("FAIL single_fifo_empty: got %0b want 0", match_valid); end
        vectors++; if (pop_q.size() == 0 || pop_q[pop_q.size()-1] !== aa) begin
            miscompares++; $display("FAIL single_popped: got %0d entries want last %h", pop_q.size(), aa);
        end
    endtask

    task automatic test_sweep256();
        logic [55:0] exp_q [$];
        logic [31:0] tg;
        int base, cyc, bad;
        tg = model_hash(cand(129, 7'h41, 2), 32'h1505);
        for (int n = 0; n < 256; n++)
            if (model_hash(cand(n, 7'h41, 2), 32'h1505) == tg) exp_q.push_back(cand(n, 7'h41, 2));
        base = pop_q.size();
        match_ready = 1'b1;
        start_sweep(7'h41, 7'h42, 32'h1505, tg);
        for (int i = 0; i < 256; i++) begin
            vectors++;
            if (hp_chars !== cand(i, 7'h41, 2) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL sweep_issue_%0d: got %h busy %0b want %h busy 1", i, hp_chars, busy, cand(i, 7'h41, 2));
            end
            @(posedge clk); #1;
        end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sweep_drain_busy: got %0b want 1", busy); end
        vectors++; if (hp_chars !== {8{7'h42}}) begin miscompares++; $display("FAIL sweep_last_chars: got %h want %h", hp_chars, {8{7'h42}}); end
        wait_done(40, cyc);
        vectors++; if (cyc < 0) begin miscompares++; $display("FAIL sweep_done: got timeout want done"); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (pop_q.size() - base != exp_q.size()) begin
            miscompares++; $display("FAIL sweep_match_count: got %0d want %0d", pop_q.size() - base, exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && base + i < pop_q.size(); i++)
            if (pop_q[base+i] !== exp_q[i]) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL sweep_match_str: got %0d wrong want 0", bad); end
        match_ready = 1'b0;
    endtask

    task automatic test_range_err();
        start_sweep(7'h42, 7'h41, 32'h1505, 32'h0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rerr_done: got %0b want 1", done); end
        vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL rerr_flag: got %0b want 1", range_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rerr_busy: got %0b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b1 || hp_chars !== {8{7'h42}}) begin
                miscompares++;
                $display("FAIL rerr_idle_%0d: got busy %0b done %0b err %0b chars %h want 0 0 1 %h",
                         i, busy, done, range_err, hp_chars, {8{7'h42}});
            end
        end
    endtask

    task automatic test_stall();
        int base, cyc, bad;
        base = pop_q.size();
        force_match = 1'b1;
        match_ready = 1'b0;
        start_sweep(7'h41, 7'h42, 32'h2222, 32'hCAFE_F00D);
        vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL stall_err_cleared: got %0b want 0", range_err); end
        repeat (40) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %0b want 1", busy); end
        vectors++; if (hp_chars !== cand(16, 7'h41, 2)) begin
            miscompares++; $display("FAIL stall_held_chars: got %h want %h", hp_chars, cand(16, 7'h41, 2));
        end
        vectors++; if (match_str !== cand(0, 7'h41, 2)) begin
            miscompares++; $display("FAIL stall_head: got %h want %h", match_str, cand(0, 7'h41, 2));
        end
        match_ready = 1'b1;
        wait_done(2000, cyc);
        vectors++; if (cyc < 0) begin miscompares++; $display("FAIL stall_done: got timeout want done"); end
        for (int i = 0; i < 40 && match_valid; i++) begin
            @(posedge clk); #1;
        end
        vectors++; if (pop_q.size() - base != 256) begin
            miscompares++; $display("FAIL stall_match_count: got %0d want 256", pop_q.size() - base);
        end
        bad = 0;
        for (int i = 0; i < 256 && base + i < pop_q.size(); i++)
            if (pop_q[base+i] !== cand(i, 7'h41, 2)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL stall_match_order: got %0d wrong want 0", bad); end
        match_ready = 1'b0;
        force_match = 1'b0;
    endtask

    task automatic test_abort();
        int base, cyc, bad;
        base = pop_q.size();
        force_match = 1'b1;
        match_ready = 1'b1;
        start_sweep(7'h41, 7'h42, 32'h3333, 32'h1234_5678);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_drain_busy: got %0b want 1", busy); end
        wait_done(40, cyc);
        vectors++; if (cyc != 8) begin miscompares++; $display("FAIL abort_drain_len: got %0d want 8", cyc); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (pop_q.size() - base != 5) begin
            miscompares++; $display("FAIL abort_issued: got %0d want 5", pop_q.size() - base);
        end
        bad = 0;
        for (int i = 0; i < 5 && base + i < pop_q.size(); i++)
            if (pop_q[base+i] !== cand(i, 7'h41, 2)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL abort_strings: got %0d wrong want 0", bad); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL abort_idle_ignored: got busy %0b done %0b want 0 0", busy, done);
        end
        match_ready = 1'b0;
        force_match = 1'b0;
    endtask

    task automatic test_reset_midrun();
        force_match = 1'b1;
        match_ready = 1'b0;
        start_sweep(7'h41, 7'h42, 32'h4444, 32'h0BAD_BEEF);
        repeat (12) @(posedge clk);
        #2;
        vectors++; if (match_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_valid: got %0b want 1", match_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        vectors++; if (hp_chars !== 56'd0) begin miscompares++; $display("FAIL midrst_hp_chars: got %h want 0", hp_chars); end
        vectors++; if (hp_seed !== 32'd0) begin miscompares++; $display("FAIL midrst_hp_seed: got %h want 0", hp_seed); end
        vectors++; if (match_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_match_valid: got %0b want 0", match_valid); end
        vectors++; if (match_str !== 56'd0) begin miscompares++; $display("FAIL midrst_match_str: got %h want 0", match_str); end
        vectors++; if (done !== 1'b0 || range_err !== 1'b0) begin
            miscompares++; $display("FAIL midrst_flags: got done %0b err %0b want 0 0", done, range_err);
        end
        force_match = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep256();
        test_range_err();
        test_stall();
        test_abort();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
